// File: rtl/systolic_cell.sv
// Systolic array cell: forwards a/b east/south one stage, emits c + a*b (pe) or 0 (de).
// Optional build macro SYSTOLIC_CELL_SAT_EN clamps pe partial sums at all-ones instead of wrapping.
module systolic_cell #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 16,
  parameter int IS_DELAY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ACC_W-1:0]  c,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [ACC_W-1:0]  cab_o
);

  localparam int PROD_W = 2 * DATA_W;

  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [ACC_W-1:0]  cab_reg;
  logic [ACC_W-1:0]  cab_next;
  logic [PROD_W-1:0] prod;
  logic [ACC_W:0]    sum_wide;
  logic [ACC_W-1:0]  mac_next;

  // Full-width unsigned product; one spare bit on the sum exposes the carry out.
  assign prod     = PROD_W'(a) * PROD_W'(b);
  assign sum_wide = (ACC_W + 1)'(c) + (ACC_W + 1)'(prod);

`ifdef SYSTOLIC_CELL_SAT_EN
  assign mac_next = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
  assign mac_next = sum_wide[ACC_W-1:0];
`endif

  assign cab_next = (IS_DELAY != 0) ? '0 : mac_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      cab_reg <= '0;
    end else begin
      a_reg   <= a;
      b_reg   <= b;
      cab_reg <= cab_next;
    end
  end

  assign a_o   = a_reg;
  assign b_o   = b_reg;
  assign cab_o = cab_reg;

endmodule

// File: tb/tb_systolic_cell.sv
// Bench for systolic_cell: directed vector table plus randomized stream against an arithmetic model.
// Runs a pe instance and a de instance side by side on a shared clock and reset.
module tb_systolic_cell;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
`ifdef SYSTOLIC_CELL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] a, b, da, db;
  logic [ACC_W-1:0]  c, dc;
  logic [DATA_W-1:0] a_o, b_o, da_o, db_o;
  logic [ACC_W-1:0]  cab_o, dcab_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  systolic_cell #(.DATA_W(DATA_W), .ACC_W(ACC_W), .IS_DELAY(0)) u_pe (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .a_o(a_o), .b_o(b_o), .cab_o(cab_o)
  );

  systolic_cell #(.DATA_W(DATA_W), .ACC_W(ACC_W), .IS_DELAY(1)) u_de (
    .clk(clk), .rst(rst), .a(da), .b(db), .c(dc),
    .a_o(da_o), .b_o(db_o), .cab_o(dcab_o)
  );

  typedef struct {
    logic              rst;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [ACC_W-1:0]  c;
    logic [DATA_W-1:0] ea;
    logic [DATA_W-1:0] eb;
    logic [ACC_W-1:0]  ecab;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [DATA_W-1:0] va, logic [DATA_W-1:0] vb,
                              logic [ACC_W-1:0] vc, logic [DATA_W-1:0] ea,
                              logic [DATA_W-1:0] eb, logic [ACC_W-1:0] ecab);
    vec_t v;
    v.rst = r; v.a = va; v.b = vb; v.c = vc; v.ea = ea; v.eb = eb; v.ecab = ecab;
    return v;
  endfunction

  // Reference: plain integer arithmetic, then wrap or clamp to the accumulator range.
  function automatic longint model_cab(longint ma, longint mb, longint mc);
    longint s;
    longint lim;
    lim = longint'(1) << ACC_W;
    s = mc + ma * mb;
    if (SAT && s >= lim) return lim - 1;
    return s % lim;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [ACC_W-1:0] ovf_exp;
    longint exp_cab;
    logic [DATA_W-1:0] pa, pb, qa, qb;
    logic [ACC_W-1:0] pc;
    logic pr;

    ovf_exp = SAT ? 16'hFFFF : 16'hFE00;
    rst = 1'b1; a = '0; b = '0; c = '0; da = '0; db = '0; dc = '0;

    // Each row: inputs applied before an edge, outputs expected after it.
    vecs.push_back(mk(1'b1, 8'h12, 8'h34, 16'h5678, 8'h00, 8'h00, 16'h0000));
    vecs.push_back(mk(1'b1, 8'h12, 8'h34, 16'h5678, 8'h00, 8'h00, 16'h0000));
    vecs.push_back(mk(1'b0, 8'd3,  8'd4,  16'd5,    8'd3,  8'd4,  16'd17));
    vecs.push_back(mk(1'b0, 8'd1,  8'd2,  16'd0,    8'd1,  8'd2,  16'd2));
    vecs.push_back(mk(1'b0, 8'd3,  8'd4,  16'd100,  8'd3,  8'd4,  16'd112));
    vecs.push_back(mk(1'b0, 8'd255, 8'd1, 16'd1,    8'd255, 8'd1, 16'd256));
    vecs.push_back(mk(1'b0, 8'd255, 8'd255, 16'hFFFF, 8'd255, 8'd255, ovf_exp));
    vecs.push_back(mk(1'b0, 8'd2,  8'd3,  16'd1,    8'd2,  8'd3,  16'd7));
    vecs.push_back(mk(1'b1, 8'd2,  8'd3,  16'd1,    8'd0,  8'd0,  16'd0));
    vecs.push_back(mk(1'b0, 8'd2,  8'd3,  16'd1,    8'd2,  8'd3,  16'd7));
    vecs.push_back(mk(1'b0, 8'd0,  8'd0,  16'd0,    8'd0,  8'd0,  16'd0));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; a = vecs[i].a; b = vecs[i].b; c = vecs[i].c;
      da = 8'd7; db = 8'd9; dc = 16'h1234;
      tick();
      chk($sformatf("pe_a_o[%0d]", i), a_o, vecs[i].ea);
      chk($sformatf("pe_b_o[%0d]", i), b_o, vecs[i].eb);
      chk($sformatf("pe_cab_o[%0d]", i), cab_o, vecs[i].ecab);
      chk($sformatf("de_a_o[%0d]", i), da_o, vecs[i].rst ? 8'd0 : 8'd7);
      chk($sformatf("de_b_o[%0d]", i), db_o, vecs[i].rst ? 8'd0 : 8'd9);
      chk($sformatf("de_cab_o[%0d]", i), dcab_o, 16'd0);
    end

    // Hand-written: outputs must hold the previous sample only for one cycle.
    rst = 1'b0; a = 8'd10; b = 8'd10; c = 16'd5;
    tick();
    a = 8'd0; b = 8'd0; c = 16'd0;
    chk("hold_cab_first", cab_o, 16'd105);
    tick();
    chk("hold_cab_cleared", cab_o, 16'd0);

    // Randomized stream, occasional reset, reset priority over data.
    for (int i = 0; i < 400; i++) begin
      pr = ($urandom_range(0, 15) == 0);
      pa = DATA_W'($urandom); pb = DATA_W'($urandom); pc = ACC_W'($urandom);
      if ($urandom_range(0, 3) == 0) pc = 16'hFF00 | ACC_W'($urandom_range(0, 255));
      qa = DATA_W'($urandom); qb = DATA_W'($urandom);
      rst = pr; a = pa; b = pb; c = pc; da = qa; db = qb; dc = ACC_W'($urandom);
      exp_cab = pr ? 0 : model_cab(longint'(pa), longint'(pb), longint'(pc));
      tick();
      chk($sformatf("rnd_cab[%0d] a=%0d b=%0d c=%0d", i, pa, pb, pc), cab_o, exp_cab);
      chk($sformatf("rnd_a[%0d]", i), a_o, pr ? 0 : longint'(pa));
      chk($sformatf("rnd_b[%0d]", i), b_o, pr ? 0 : longint'(pb));
      chk($sformatf("rnd_de_a[%0d]", i), da_o, pr ? 0 : longint'(qa));
      chk($sformatf("rnd_de_b[%0d]", i), db_o, pr ? 0 : longint'(qb));
      chk($sformatf("rnd_de_cab[%0d]", i), dcab_o, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
